// File: rtl/dequantize_pkg.sv
// Shared constants for the dequantizer: lane geometry, data widths, mode
// encodings and controller state encodings.
package dequantize_pkg;

  localparam int DQ_VL        = 16;
  localparam int DQ_TRUNC_W   = 18;
  localparam int DQ_ADDR_W    = 10;
  localparam int DQ_DATA4_W   = 4;
  localparam int DQ_DATA8_W   = 8;
  localparam int DQ_VSQ_BUF_D = 16;
  localparam int DQ_M         = 64;
  localparam int DQ_N         = 16;
  localparam int DQ_TOTAL_ROWS = (DQ_M / DQ_VL) * DQ_N;

  // Scale/data modes; any value other than these decodes as INT8.
  localparam logic [1:0] MODE_INT4_VSQ = 2'd0;
  localparam logic [1:0] MODE_INT4     = 2'd1;
  localparam logic [1:0] MODE_INT8     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_SF,
    S_RUN,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/dequant_lane.sv
// One dequantizer lane: sign-extend the INT4 or INT8 code, multiply by the
// unsigned scale and saturate to a signed TRUNC_W result. Purely combinational.
module dequant_lane
  import dequantize_pkg::*;
#(
  parameter int TRUNC_W = DQ_TRUNC_W
) (
  input  logic [DQ_DATA8_W-1:0]     q8,
  input  logic [DQ_DATA4_W-1:0]     q4,
  input  logic                      int4,
  input  logic [TRUNC_W-1:0]        sf,
  output logic signed [TRUNC_W-1:0] y
);

  // Product width holds any 8-bit signed code times an unsigned TRUNC_W scale.
  localparam int PW = TRUNC_W + 9;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-TRUNC_W+1){1'b0}}, {(TRUNC_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-TRUNC_W+1){1'b1}}, {(TRUNC_W-1){1'b0}}};

  function automatic logic signed [TRUNC_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[TRUNC_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[TRUNC_W-1:0];
    return v[TRUNC_W-1:0];
  endfunction

  logic signed [PW-1:0] q_ext;
  logic signed [PW-1:0] sf_ext;
  logic signed [PW-1:0] prod;

  // Exact product of the signed code and zero-extended scale, then clamp.
  always_comb begin
    q_ext  = int4 ? PW'(signed'(q4)) : PW'(signed'(q8));
    sf_ext = signed'(PW'(sf));
    prod   = q_ext * sf_ext;
    y      = sat(prod);
  end

endmodule

// File: rtl/dequantize.sv
// Dequantizer: streams packed INT4/INT8 rows from the quantized output RAM,
// scales each lane (per-lane VSQ or per-tensor scale) and emits saturated
// signed TRUNC_W vectors with row index and group/matrix end flags.
module dequantize
  import dequantize_pkg::*;
#(
  parameter int VL         = DQ_VL,
  parameter int TRUNC_W    = DQ_TRUNC_W,
  parameter int ADDR_W     = DQ_ADDR_W,
  parameter int GROUP_D    = DQ_VSQ_BUF_D,
  parameter int TOTAL_ROWS = DQ_TOTAL_ROWS
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  output logic                    o_ram_re,
  output logic [ADDR_W-1:0]       o_ram_addr,
  input  logic [8*VL-1:0]         i_ram_data,
  output logic                    o_sf_req,
  input  logic                    i_sf_valid,
  input  logic [TRUNC_W*VL-1:0]   i_sf,
  output logic                    o_valid,
  output logic [TRUNC_W*VL-1:0]   o_data,
  output logic [ADDR_W-1:0]       o_addr,
  output logic                    o_vec_last,
  output logic                    o_finish,
  output logic                    o_busy
);

  localparam int GW = $clog2(GROUP_D + 1);
  localparam logic [GW-1:0]     GRP_LAST = GW'(GROUP_D - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(TOTAL_ROWS - 1);

  state_t                  state, state_nxt;
  logic [1:0]              mode_q;
  logic [GW-1:0]           grp_cnt;
  logic [ADDR_W-1:0]       tot_cnt;
  logic [TRUNC_W*VL-1:0]   sf_q;
  logic                    vld_p1, last_p1, fin_p1;
  logic [ADDR_W-1:0]       addr_p1;
  logic [TRUNC_W*VL-1:0]   lane_y;
  logic                    is_vsq, is_int4, pipe_empty, sf_take, row_last, grp_last;

  assign is_vsq     = (mode_q == MODE_INT4_VSQ);
  assign is_int4    = is_vsq || (mode_q == MODE_INT4);
  assign pipe_empty = !vld_p1 && !o_valid;
  // Scales are only swapped when no row still depends on the old set.
  assign o_sf_req   = (state == S_LOAD_SF) && pipe_empty;
  assign sf_take    = o_sf_req && i_sf_valid;
  assign o_ram_re   = (state == S_RUN);
  assign o_ram_addr = tot_cnt;
  assign o_busy     = (state != S_IDLE);
  assign row_last   = (tot_cnt == ROW_LAST);
  assign grp_last   = (grp_cnt == GRP_LAST);

  // Controller state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: load scales, stream rows, reload per VSQ group, drain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start) state_nxt = S_LOAD_SF;
      S_LOAD_SF: if (sf_take) state_nxt = S_RUN;
      S_RUN: begin
        if (row_last)              state_nxt = S_DRAIN;
        else if (is_vsq && grp_last) state_nxt = S_LOAD_SF;
      end
      S_DRAIN:   if (pipe_empty) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Mode latch, row/group counters and scale capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q  <= '0;
      grp_cnt <= '0;
      tot_cnt <= '0;
      sf_q    <= '0;
    end else begin
      if (state == S_IDLE && i_start) begin
        mode_q  <= i_mode;
        grp_cnt <= '0;
        tot_cnt <= '0;
      end
      if (sf_take) sf_q <= i_sf;
      if (state == S_RUN) begin
        tot_cnt <= tot_cnt + 1'b1;
        grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
      end
    end
  end

  // ---- stage 0 -> 1: row issued to RAM; tags travel with the read ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      fin_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= o_ram_re;
      last_p1 <= row_last || (is_vsq && grp_last);
      fin_p1  <= row_last;
      addr_p1 <= tot_cnt;
    end
  end

  for (genvar i = 0; i < VL; i++) begin : g_lane
    dequant_lane #(.TRUNC_W(TRUNC_W)) u_lane (
      .q8   (i_ram_data[8*i +: 8]),
      .q4   (i_ram_data[4*i +: 4]),
      .int4 (is_int4),
      .sf   (is_vsq ? sf_q[TRUNC_W*i +: TRUNC_W] : sf_q[0 +: TRUNC_W]),
      .y    (lane_y[TRUNC_W*i +: TRUNC_W])
    );
  end

  // ---- stage 1 -> 2: scaled lanes registered to the outputs ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_vec_last <= 1'b0;
      o_finish   <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
    end else begin
      o_valid    <= vld_p1;
      o_vec_last <= vld_p1 && last_p1;
      o_finish   <= vld_p1 && fin_p1;
      if (vld_p1) begin
        o_data <= lane_y;
        o_addr <= addr_p1;
      end
    end
  end

endmodule

// File: doc/dequantize.md
Name: dequantize

Overview:
- Inverse of the quantizer. Reads packed INT4/INT8 vectors from the quantized output RAM and multiplies each lane by its scale factor. Produces saturated TRUNC_W fixed-point vectors for the next layer or for golden comparison.
- Supports three scale modes: per-lane VSQ scales (one set per vector group), per-tensor INT4, and per-tensor INT8.
- Sits between the quantized output RAM and the downstream datapath. The scale-factor source hands scales over with a request/valid handshake.

Parameters:
VL, 16, lanes per vector
TRUNC_W, 18, bit width of scale factors and dequantized lanes
ADDR_W, 10, RAM address width
GROUP_D, 16, rows per VSQ vector group (= VSQ_BUF_D)
TOTAL_ROWS, 64, rows per matrix (= (M/VL)*N)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  one-cycle pulse: begin a matrix
i_mode  in  2  INT4_VSQ / INT4 / INT8 encodings from define.v; any other value means INT8
o_ram_re  out  1  RAM read enable
o_ram_addr  out  ADDR_W  RAM read address (row index)
i_ram_data  in  8*VL  packed row, valid the cycle after o_ram_re
o_sf_req  out  1  requests the next scale set
i_sf_valid  in  1  i_sf holds a valid scale set
i_sf  in  TRUNC_W*VL  unsigned scales; lane 0 only is used in INT4/INT8
o_valid  out  1  o_data/o_addr valid
o_data  out  TRUNC_W*VL  signed dequantized lanes
o_addr  out  ADDR_W  row index of o_data
o_vec_last  out  1  last row of a group, qualified by o_valid
o_finish  out  1  one-cycle pulse with the final row's o_valid
o_busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous. i_rst_n=0 at a posedge forces:
  - state to IDLE;
  - all counters, pipeline valid bits, scale registers and outputs to 0.
  - This includes reset mid-operation; any in-flight rows are discarded.
- States:
  - IDLE: on i_start, latch i_mode, clear the row counters, go to LOAD_SF.
  - LOAD_SF:
    - o_sf_req=1 only while the pipeline is empty (both stage valids 0).
    - i_sf_valid is ignored while the pipeline is non-empty.
    - On i_sf_valid with o_sf_req=1, capture i_sf and go to RUN.
  - RUN: each cycle, o_ram_re=1 and o_ram_addr=tot_cnt; grp_cnt and tot_cnt increment.
    - At tot_cnt==TOTAL_ROWS-1, go to DRAIN.
    - Otherwise, in VSQ mode at grp_cnt==GROUP_D-1, clear grp_cnt and go to LOAD_SF.
    - INT4/INT8 stay in RUN for the whole matrix.
  - DRAIN: when the pipeline is empty, go to IDLE.
- i_start outside IDLE is ignored.
- Pipeline and latency:
  - Row r is issued at cycle t. i_ram_data arrives at t+1 together with a stage-1 valid, row index and last flags.
  - The multiply/saturate result is registered to o_data with o_valid=1 at t+2.
  - In RUN there are no bubbles: one row per cycle.
- Unpacking:
  - INT8: lane i = i_ram_data[8i+:8] signed.
  - INT4/INT4_VSQ: lane i = i_ram_data[4i+:4] signed. Bits [8*VL-1:4*VL] are ignored.
- Arithmetic:
  - Product = sext(q) * zext(sf_lane), evaluated at TRUNC_W+9 bits signed.
  - Saturate to signed TRUNC_W: max 2^(TRUNC_W-1)-1, min -2^(TRUNC_W-1).
  - No rounding and no shift: q*sf is exact in the data format.
- Scale selection:
  - VSQ: lane i uses sf[i].
  - INT4/INT8: every lane uses sf[0], loaded once per matrix.
- Flags:
  - o_vec_last is set on the last row of each VSQ group, and on row TOTAL_ROWS-1 in every mode.
  - If TOTAL_ROWS is not a multiple of GROUP_D, the final partial group ends at TOTAL_ROWS-1 with o_vec_last=1.
  - o_finish is a single-cycle pulse coincident with the o_valid of row TOTAL_ROWS-1.
- Outputs are registered. o_data holds its last value while o_valid=0.

Decomposition:
- Mode encodings (INT4_VSQ, INT4, INT8) and the width macros TRUNC_W, DATA4_W, DATA8_W, ADDR_W, VL, VSQ_BUF_D, M, N stay in the shared define.v. No new constants are local to the block except the state encodings.
- Sub-module dequant_lane: one-lane sign-extend, multiply, saturate. It is purely combinational and is instantiated VL times in a generate loop.

Test Plan:
- INT8, sf[0]=1000, row with lane0=0x80, lane1=0x7F, others 0 -> lane0=-128000, lane1=127000, others 0. o_valid 2 cycles after o_ram_re for that row.
- INT8, sf[0]=2000, lane0=0x7F, lane1=0x80 -> lane0 saturates to 131071, lane1 saturates to -131072.
- INT4, sf[0]=3, low nibbles 0x8,0x7,0xF,0x1 -> -24, 21, -3, 3. The upper 64 bits of i_ram_data set to all ones have no effect.
- INT4_VSQ, TOTAL_ROWS=32, GROUP_D=16, sf[i]=i+1 for group 0 and 2*(i+1) for group 1:
  - exactly 2 o_sf_req handshakes;
  - o_sf_req stays low until group 0's last output has left the pipeline;
  - lane i of row 20 holding 1 -> 2*(i+1);
  - o_vec_last on rows 15 and 31; o_finish once, on row 31.
- i_sf_valid held low for 5 cycles in LOAD_SF -> no o_ram_re and no o_valid until it rises. A second i_start during RUN is ignored, so only 64 o_valid in total.
- i_rst_n low for 1 cycle mid-RUN at row 10 -> next cycle all outputs 0 and state IDLE. A fresh i_start then restarts from row 0.
